// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC arbiter slice.
// Holds the op-code map, response status codes and the arbiter FSM state encoding.
package cordic_pkg;

  // CORDIC operation codes; anything above OP_MAX is rejected without touching the core.
  localparam logic [3:0] SIN     = 4'b0000;
  localparam logic [3:0] COS     = 4'b0001;
  localparam logic [3:0] ATAN    = 4'b0010;
  localparam logic [3:0] MOD     = 4'b0011;
  localparam logic [3:0] SINH    = 4'b0100;
  localparam logic [3:0] COSH    = 4'b0101;
  localparam logic [3:0] ATANH   = 4'b0110;
  localparam logic [3:0] EXP     = 4'b0111;
  localparam logic [3:0] LN      = 4'b1000;
  localparam logic [3:0] MODH    = 4'b1001;
  localparam logic [3:0] DEFAULT = 4'b1111;
  localparam logic [3:0] OP_MAX  = 4'b1001;

  // Response status codes.
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADOP   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side bus of the CORDIC arbiter.
// master: client side (drives requests, receives responses).
// slave : arbiter side (accepts requests, returns one-hot responses).
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot accept pulse
//   req_op/x/y/z        : packed per-requester op code and operands
//   rsp_valid           : one-hot response pulse, rsp_result/rsp_status valid with it
interface cordic_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [4*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_x;
  logic [WIDTH*N_REQ-1:0] req_y;
  logic [WIDTH*N_REQ-1:0] req_z;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_result;
  logic [1:0]             rsp_status;

  modport master (
    output req_valid, req_op, req_x, req_y, req_z,
    input  req_ready, rsp_valid, rsp_result, rsp_status
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_z,
    output req_ready, rsp_valid, rsp_result, rsp_status
  );

endinterface

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   grant     : first set index at or after ptr, wrapping modulo N_REQ
//   any_valid : at least one request present
module cordic_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  logic [2*N_REQ-1:0] rot;
  logic [ID_W:0]      sum;

  always_comb begin
    // Rotating the doubled vector puts the pointer position at bit 0.
    rot = {req, req} >> ptr;
    sum = '0;
    // Walk downwards so the smallest offset from ptr is the one that sticks.
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (ID_W+1)'(i);
      end
    end
    if (sum >= (ID_W+1)'(N_REQ)) begin
      sum = sum - (ID_W+1)'(N_REQ);
    end
    grant     = sum[ID_W-1:0];
    any_valid = |req;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC core between N_REQ requesters.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : requester handshake, operands and one-hot responses
//   busy           : high whenever an operation is in progress
//   grant_id       : index of the current or last granted requester
//   cor_enable     : one-cycle start pulse to the CORDIC
//   cor_operation  : op code to the CORDIC (DEFAULT when idle)
//   cor_x/y/z_in   : operands to the CORDIC (zero when idle)
//   cor_result     : CORDIC result
//   cor_done       : CORDIC done level; only its rising edge in WAIT completes an op
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  cordic_arbiter_if.slave  bus,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             cor_enable,
  output logic [3:0]       cor_operation,
  output logic [WIDTH-1:0] cor_x_in,
  output logic [WIDTH-1:0] cor_y_in,
  output logic [WIDTH-1:0] cor_z_in,
  input  logic [WIDTH-1:0] cor_result,
  input  logic             cor_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [1:0]        status_q, status_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;

  logic [ID_W-1:0]   pick_idx;
  logic              any_valid;
  logic [3:0]        sel_op;
  logic [WIDTH-1:0]  sel_x, sel_y, sel_z;
  logic              done_rise;
  logic              idle;

  cordic_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (pick_idx),
    .any_valid (any_valid)
  );

  // Operand mux for the picked requester.
  always_comb begin
    sel_op = '0;
    sel_x  = '0;
    sel_y  = '0;
    sel_z  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_op = bus.req_op[4*i +: 4];
        sel_x  = bus.req_x[WIDTH*i +: WIDTH];
        sel_y  = bus.req_y[WIDTH*i +: WIDTH];
        sel_z  = bus.req_z[WIDTH*i +: WIDTH];
      end
    end
  end

  // A done level left high by the previous operation must not count as completion.
  assign done_rise = cor_done & ~done_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    op_d          = op_q;
    x_d           = x_q;
    y_d           = y_q;
    z_d           = z_q;
    result_d      = result_q;
    status_d      = status_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;

    case (state_q)
      StIdle: begin
        if (any_valid) begin
          bus.req_ready[pick_idx] = 1'b1;
          grant_d = pick_idx;
          op_d    = sel_op;
          x_d     = sel_x;
          y_d     = sel_y;
          z_d     = sel_z;
          if (sel_op <= OP_MAX) begin
            state_d = StIssue;
          end else begin
            status_d = ST_BADOP;
            result_d = '0;
            state_d  = StResp;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (done_rise) begin
          result_d = cor_result;
          status_d = ST_OK;
          state_d  = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          status_d = ST_TIMEOUT;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      op_q     <= DEFAULT;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      status_q <= ST_OK;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      result_q <= result_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      done_q   <= cor_done;
    end
  end

  assign idle          = (state_q == StIdle);
  assign busy          = ~idle;
  assign grant_id      = grant_q;
  assign cor_enable    = (state_q == StIssue);
  assign cor_operation = idle ? DEFAULT : op_q;
  assign cor_x_in      = idle ? '0 : x_q;
  assign cor_y_in      = idle ? '0 : y_q;
  assign cor_z_in      = idle ? '0 : z_q;

  always_comb begin
    bus.rsp_valid = '0;
    if (state_q == StResp) begin
      bus.rsp_valid[grant_q] = 1'b1;
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_status = status_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  logic             busy;
  logic [ID_W-1:0]  grant_id;
  logic             cor_enable;
  logic [3:0]       cor_operation;
  logic [WIDTH-1:0] cor_x_in, cor_y_in, cor_z_in, cor_result;
  logic             cor_done;

  cordic_arbiter #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .grant_id(grant_id),
    .cor_enable(cor_enable), .cor_operation(cor_operation),
    .cor_x_in(cor_x_in), .cor_y_in(cor_y_in), .cor_z_in(cor_z_in),
    .cor_result(cor_result), .cor_done(cor_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub CORDIC: done rises stub_delay cycles into WAIT and stays high; 0 means never.
  int          stub_delay  = 5;
  logic [31:0] stub_result = '0;
  bit          stub_sqrt   = 1'b0;
  int          stub_cnt    = 0;
  bit          stub_active = 1'b0;
  always @(posedge clk) begin
    if (cor_enable) begin
      stub_cnt    <= 0;
      stub_active <= 1'b1;
    end else if (stub_active && stub_cnt < 100000) begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign cor_done = stub_active && (stub_delay > 0) && (stub_cnt >= stub_delay);

  function automatic logic [31:0] modh(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = $itor($signed(x)) / 65536.0;
    ry = $itor($signed(y)) / 65536.0;
    if (rx * rx <= ry * ry) return '0;
    return 32'($rtoi($sqrt(rx * rx - ry * ry) * 65536.0));
  endfunction
  assign cor_result = stub_sqrt ? modh(cor_x_in, cor_y_in) : stub_result;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    bus.req_valid[i]        = v;
    bus.req_op[4*i +: 4]    = op;
    bus.req_x[32*i +: 32]   = x;
    bus.req_y[32*i +: 32]   = y;
    bus.req_z[32*i +: 32]   = z;
  endtask

  // Tasks start and end at posedge+1 (drive point); outputs are sampled at posedge+2.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [31:0] x, y, z;
    int          delay;
    logic [31:0] res;
    bit          sqrt;
    int          exp_lat;
    logic [1:0]  exp_st;
    logic [31:0] exp_res;
    int          exp_en;
  } vec_t;

  task automatic run_vec(input int k, input vec_t v);
    int t_acc, n_en, z_bad, lat;
    bit acc, got;
    logic [3:0] rv;
    logic [31:0] res;
    logic [1:0] st;
    logic [ID_W-1:0] gid;
    int diff;
    acc = 0; got = 0; n_en = 0; z_bad = 0; lat = -1; t_acc = 0;
    rv = '0; res = '0; st = '0; gid = '0;
    stub_delay = v.delay; stub_result = v.res; stub_sqrt = v.sqrt;
    drive_req(v.idx, 1'b1, v.op, v.x, v.y, v.z);
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (cor_enable) n_en++;
      if (acc && busy && cor_z_in !== v.z) z_bad++;
      if (!acc && bus.req_ready[v.idx]) begin
        acc = 1; t_acc = cyc;
      end else if (acc && bus.rsp_valid != '0) begin
        got = 1; lat = cyc - t_acc; rv = bus.rsp_valid;
        res = bus.rsp_result; st = bus.rsp_status; gid = grant_id;
      end
      @(posedge clk); #1;
      if (acc) bus.req_valid[v.idx] = 1'b0;
    end
    check($sformatf("vec%0d_rsp_seen", k), 64'(got), 64'd1);
    check($sformatf("vec%0d_latency", k), 64'(lat), 64'(v.exp_lat));
    check($sformatf("vec%0d_rsp_valid", k), 64'(rv), 64'(4'b1 << v.idx));
    check($sformatf("vec%0d_status", k), 64'(st), 64'(v.exp_st));
    if (v.sqrt) begin
      diff = int'(res) - int'(v.exp_res);
      check($sformatf("vec%0d_result_near", k), 64'(diff <= 6553 && diff >= -6553), 64'd1);
    end else begin
      check($sformatf("vec%0d_result", k), 64'(res), 64'(v.exp_res));
    end
    check($sformatf("vec%0d_enable_pulses", k), 64'(n_en), 64'(v.exp_en));
    check($sformatf("vec%0d_z_held", k), 64'(z_bad), 64'd0);
    check($sformatf("vec%0d_grant_id", k), 64'(gid), 64'(v.idx));
    stub_sqrt = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle_seen;
    idle_seen = 0;
    for (int c = 0; c < 200 && !idle_seen; c++) begin
      #1;
      if (!busy) idle_seen = 1;
      @(posedge clk); #1;
    end
    check(tag, 64'(idle_seen), 64'd1);
  endtask

  task automatic rr_burst(input logic [3:0] mask, input int n, input int e0, input int e1,
                          input int e2, input int e3, input string tag);
    int order[$];
    int exp_o[4];
    bit multi;
    logic [3:0] drop;
    exp_o = '{e0, e1, e2, e3};
    multi = 0;
    stub_delay = 2; stub_result = 32'h1;
    for (int i = 0; i < 4; i++) if (mask[i]) drive_req(i, 1'b1, SIN, '0, '0, 32'(i));
    for (int c = 0; c < 400 && order.size() < n; c++) begin
      #1;
      drop = '0;
      if ($countones(bus.req_ready) > 1) multi = 1;
      for (int i = 0; i < 4; i++) if (bus.req_ready[i]) begin
        order.push_back(i); drop[i] = 1'b1;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (drop[i]) bus.req_valid[i] = 1'b0;
    end
    check({tag, "_count"}, 64'(order.size()), 64'(n));
    for (int k = 0; k < n; k++)
      check($sformatf("%s_order%0d", tag, k), 64'((k < order.size()) ? order[k] : -1),
            64'(exp_o[k]));
    check({tag, "_ready_onehot"}, 64'(multi), 64'd0);
    wait_idle({tag, "_idle"});
  endtask

  task automatic reset_mid();
    bit acc;
    int n_rsp;
    acc = 0; n_rsp = 0;
    stub_delay = 30; stub_result = 32'h55;
    drive_req(2, 1'b1, COS, 32'h10, 32'h20, 32'h30);
    for (int c = 0; c < 50 && !acc; c++) begin
      #1;
      if (bus.req_ready[2]) acc = 1;
      @(posedge clk); #1;
    end
    check("rstmid_accept", 64'(acc), 64'd1);
    bus.req_valid[2] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_cor_op", 64'(cor_operation), 64'(4'hF));
    check("rstmid_outputs_zero",
          64'({cor_enable, cor_x_in, cor_y_in, cor_z_in, bus.rsp_valid, bus.rsp_result,
               bus.rsp_status, grant_id, bus.req_ready} != '0), 64'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.rsp_valid != '0) n_rsp++;
      @(posedge clk); #1;
    end
    check("rstmid_no_rsp", 64'(n_rsp), 64'd0);
  endtask

  // Transaction-timing reference: accept when idle and something pends (round-robin from
  // the pointer), response at accept+1 (bad op), accept+3+delay (done) or accept+66 (timeout).
  task automatic random_phase(input int n_cycles);
    bit          pend[4];
    logic [3:0]  rop[4];
    logic [31:0] rx[4], ry[4], rz[4];
    int m_ptr, m_free, m_acc, m_rsp, m_id, c, g, d;
    logic [31:0] m_res, m_z;
    logic [1:0]  m_st;
    logic [3:0]  m_op, exp_ready, exp_rsp;
    bit found, inflight;
    m_ptr = 0; m_free = 0; m_acc = -100; m_rsp = -100; m_id = 0;
    m_res = '0; m_z = '0; m_st = '0; m_op = DEFAULT;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0; rop[i] = '0; rx[i] = '0; ry[i] = '0; rz[i] = '0;
    end
    for (int k = 0; k < n_cycles; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 4) == 0) begin
          pend[i] = 1;
          rop[i]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
          rx[i] = $urandom; ry[i] = $urandom; rz[i] = $urandom;
        end
        drive_req(i, pend[i], rop[i], rx[i], ry[i], rz[i]);
      end
      #1;
      c = cyc;
      exp_ready = '0;
      found = 0; g = 0;
      if (c >= m_free) begin
        for (int s = 0; s < 4; s++) begin
          if (!found && pend[(m_ptr + s) % 4]) begin
            found = 1; g = (m_ptr + s) % 4;
          end
        end
      end
      if (found) begin
        exp_ready[g] = 1'b1;
        m_acc = c; m_id = g; m_op = rop[g]; m_z = rz[g];
        pend[g] = 0;
        if (rop[g] > 4'd9) begin
          m_rsp = c + 1; m_st = 2'b10; m_res = '0;
        end else begin
          d = $urandom_range(0, 70);
          stub_delay = d; stub_result = $urandom;
          if (d == 0 || d > 63) begin
            m_rsp = c + 66; m_st = 2'b01; m_res = '0;
          end else begin
            m_rsp = c + 3 + d; m_st = 2'b00; m_res = stub_result;
          end
        end
        m_free = m_rsp + 1;
        m_ptr  = (g + 1) % 4;
      end
      check("rand_req_ready", 64'(bus.req_ready), 64'(exp_ready));
      exp_rsp = (c == m_rsp) ? (4'b1 << m_id) : 4'b0;
      check("rand_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
      if (c == m_rsp) begin
        check("rand_rsp_status", 64'(bus.rsp_status), 64'(m_st));
        check("rand_rsp_result", 64'(bus.rsp_result), 64'(m_res));
      end
      inflight = (c > m_acc) && (c <= m_rsp);
      check("rand_busy", 64'(busy), 64'(inflight));
      check("rand_cor_enable", 64'(cor_enable), 64'((c == m_acc + 1) && (m_op <= 4'd9)));
      check("rand_cor_op", 64'(cor_operation), 64'(inflight ? m_op : 4'hF));
      check("rand_cor_z", 64'(cor_z_in), 64'(inflight ? m_z : 32'd0));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) bus.req_valid[i] = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_z     = '0;

    vecs[0] = '{0, SIN,   32'd0,      32'd0,     32'd32768, 18, 32'h5A5A,     0, 21, 2'b00, 32'h5A5A,     1};
    vecs[1] = '{1, 4'hA,  32'd1,      32'd2,     32'd3,     5,  32'h1234,     0, 1,  2'b10, 32'd0,        0};
    vecs[2] = '{2, 4'hF,  32'd7,      32'd8,     32'd9,     5,  32'h1234,     0, 1,  2'b10, 32'd0,        0};
    vecs[3] = '{3, COS,   32'd65536,  32'd0,     32'd0,     1,  32'hFFFF0000, 0, 4,  2'b00, 32'hFFFF0000, 1};
    vecs[4] = '{1, ATAN,  32'd100,    32'd200,   32'd300,   0,  32'h777,      0, 66, 2'b01, 32'd0,        1};
    vecs[5] = '{2, MOD,   32'd5,      32'd6,     32'd11,    63, 32'hABCD,     0, 66, 2'b00, 32'hABCD,     1};
    vecs[6] = '{0, 4'h9,  32'd1,      32'd1,     32'd12,    64, 32'h99,       0, 66, 2'b01, 32'd0,        1};
    vecs[7] = '{3, MODH,  32'd131072, 32'd65536, 32'd0,     12, 32'd0,        1, 15, 2'b00, 32'd113512,   1};
    vecs[8] = '{1, SINH,  32'd3,      32'd4,     32'd5,     5,  32'd42,       0, 8,  2'b00, 32'd42,       1};

    do_reset();
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cor_op", 64'(cor_operation), 64'(4'hF));
    check("reset_outputs_zero",
          64'({cor_enable, cor_x_in, cor_y_in, cor_z_in, bus.rsp_valid, bus.rsp_result,
               bus.rsp_status, grant_id, bus.req_ready} != '0), 64'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    do_reset();
    rr_burst(4'b1111, 4, 0, 1, 2, 3, "rr_all");
    rr_burst(4'b0101, 2, 0, 2, 0, 0, "rr_02");

    reset_mid();

    do_reset();
    random_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
